// File: rtl/alpha_branch_predictor.sv
// alpha_branch_predictor
//   Tournament branch predictor in the style of the Alpha 21264. It combines
//   three predictors:
//     - a local predictor: a per-PC history table (LHT) that indexes a table
//       of LCNT_W-bit counters (LPT);
//     - a global predictor: 2-bit counters (GP) indexed by path history;
//     - a choice predictor: 2-bit counters (CP) indexed by path history,
//       which picks between the local and global predictions.
//   One branch is handled per fixed 8-cycle slot. A slot samples the PC,
//   makes a prediction, and then trains on the resolved outcome.
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-high; clears every table and register
//   PC               branch PC, sampled in phase 0 only
//   BranchTaken      resolved outcome, sampled in phase 4 only
//   PredictedBranch  registered prediction (1 = taken), updated in phase 3
//
// Slot phases
//   phase        | meaning
//   PH_FETCH     | capture PC
//   PH_HIST      | read local history for the PC, snapshot path history
//   PH_LOOKUP    | read local, global and choice counters
//   PH_PREDICT   | drive PredictedBranch from the chosen predictor
//   PH_TRAIN     | update CP, LPT, GP, LHT and path history with the outcome
//   PH_IDLE5..7  | no activity
module alpha_branch_predictor #(
  parameter int PC_W   = 10,
  parameter int LH_W   = 10,
  parameter int PH_W   = 12,
  parameter int LCNT_W = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-1:0] PC,
  input  logic            BranchTaken,
  output logic            PredictedBranch
);

  typedef enum logic [2:0] {
    PH_FETCH   = 3'd0,
    PH_HIST    = 3'd1,
    PH_LOOKUP  = 3'd2,
    PH_PREDICT = 3'd3,
    PH_TRAIN   = 3'd4,
    PH_IDLE5   = 3'd5,
    PH_IDLE6   = 3'd6,
    PH_IDLE7   = 3'd7
  } phase_t;

  localparam logic [LCNT_W-1:0] LCNT_MAX = '1;
  localparam logic [1:0]        CNT2_MAX = 2'd3;

  phase_t phase, phase_next;

  logic [LH_W-1:0]   lht [2**PC_W];
  logic [LCNT_W-1:0] lpt [2**LH_W];
  logic [1:0]        gp  [2**PH_W];
  logic [1:0]        cp  [2**PH_W];
  logic [PH_W-1:0]   path_hist;

  logic [PC_W-1:0]   pc_q;
  logic [LH_W-1:0]   lh_q;
  logic [PH_W-1:0]   ph_q;
  logic              loc_q;
  logic              glb_q;
  logic              cho_q;

  // Training values, consumed only in PH_TRAIN.
  logic              loc_right;
  logic              glb_right;
  logic [1:0]        cp_cur, cp_nxt;
  logic [1:0]        gp_cur, gp_nxt;
  logic [LCNT_W-1:0] lpt_cur, lpt_nxt;

  always_comb begin
    phase_next = PH_FETCH;
    case (phase)
      PH_FETCH:   phase_next = PH_HIST;
      PH_HIST:    phase_next = PH_LOOKUP;
      PH_LOOKUP:  phase_next = PH_PREDICT;
      PH_PREDICT: phase_next = PH_TRAIN;
      PH_TRAIN:   phase_next = PH_IDLE5;
      PH_IDLE5:   phase_next = PH_IDLE6;
      PH_IDLE6:   phase_next = PH_IDLE7;
      PH_IDLE7:   phase_next = PH_FETCH;
      default:    phase_next = PH_FETCH;
    endcase
  end

  always_comb begin
    loc_right = (loc_q == BranchTaken);
    glb_right = (glb_q == BranchTaken);
    cp_cur    = cp[ph_q];
    gp_cur    = gp[ph_q];
    lpt_cur   = lpt[lh_q];

    // Choice moves toward whichever predictor alone was right; ties leave it.
    cp_nxt = cp_cur;
    if (glb_right && !loc_right && (cp_cur != CNT2_MAX)) begin
      cp_nxt = cp_cur + 2'd1;
    end else if (loc_right && !glb_right && (cp_cur != 2'd0)) begin
      cp_nxt = cp_cur - 2'd1;
    end

    lpt_nxt = lpt_cur;
    if (BranchTaken && (lpt_cur != LCNT_MAX)) begin
      lpt_nxt = lpt_cur + LCNT_W'(1);
    end else if (!BranchTaken && (lpt_cur != '0)) begin
      lpt_nxt = lpt_cur - LCNT_W'(1);
    end

    gp_nxt = gp_cur;
    if (BranchTaken && (gp_cur != CNT2_MAX)) begin
      gp_nxt = gp_cur + 2'd1;
    end else if (!BranchTaken && (gp_cur != 2'd0)) begin
      gp_nxt = gp_cur - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= PH_FETCH;
    end else begin
      phase <= phase_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lht             <= '{default: '0};
      lpt             <= '{default: '0};
      gp              <= '{default: '0};
      cp              <= '{default: '0};
      path_hist       <= '0;
      pc_q            <= '0;
      lh_q            <= '0;
      ph_q            <= '0;
      loc_q           <= 1'b0;
      glb_q           <= 1'b0;
      cho_q           <= 1'b0;
      PredictedBranch <= 1'b0;
    end else begin
      case (phase)
        PH_FETCH: begin
          pc_q <= PC;
        end
        PH_HIST: begin
          lh_q <= lht[pc_q];
          ph_q <= path_hist;
        end
        PH_LOOKUP: begin
          // MSB set means the counter is in its upper (taken) half.
          loc_q <= lpt[lh_q][LCNT_W-1];
          glb_q <= gp[ph_q][1];
          cho_q <= cp[ph_q][1];
        end
        PH_PREDICT: begin
          PredictedBranch <= cho_q ? glb_q : loc_q;
        end
        PH_TRAIN: begin
          cp[ph_q]   <= cp_nxt;
          lpt[lh_q]  <= lpt_nxt;
          gp[ph_q]   <= gp_nxt;
          lht[pc_q]  <= {lh_q[LH_W-2:0], BranchTaken};
          path_hist  <= {BranchTaken, ph_q[PH_W-1:1]};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alpha_branch_predictor.sv
// tb_alpha_branch_predictor
//   Directed bench for alpha_branch_predictor. Each slot pushes its expected
//   prediction onto a queue; the value is popped and compared once the
//   phase-3 output is registered. Expected values come from spec constants
//   or from a slot-level behavioural model of the tables.
module tb_alpha_branch_predictor;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] PC;
  logic       BranchTaken;
  logic       PredictedBranch;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  logic [9:0]  m_lht [1024];
  logic [2:0]  m_lpt [1024];
  logic [1:0]  m_gp  [4096];
  logic [1:0]  m_cp  [4096];
  logic [11:0] m_ph;

  alpha_branch_predictor #(
    .PC_W(10), .LH_W(10), .PH_W(12), .LCNT_W(3)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .PC             (PC),
    .BranchTaken    (BranchTaken),
    .PredictedBranch(PredictedBranch)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void model_reset();
    for (int i = 0; i < 1024; i++) begin
      m_lht[i] = '0;
      m_lpt[i] = '0;
    end
    for (int i = 0; i < 4096; i++) begin
      m_gp[i] = '0;
      m_cp[i] = '0;
    end
    m_ph = '0;
  endfunction

  function automatic bit model_slot(input logic [9:0] pc, input bit t);
    logic [9:0]  lh;
    logic [11:0] ph;
    bit loc, glb, cho, pred;
    lh   = m_lht[pc];
    ph   = m_ph;
    loc  = (m_lpt[lh] >= 3'd4);
    glb  = (m_gp[ph] >= 2'd2);
    cho  = (m_cp[ph] >= 2'd2);
    pred = cho ? glb : loc;
    if ((glb == t) && (loc != t)) begin
      if (m_cp[ph] != 2'd3) m_cp[ph] = m_cp[ph] + 2'd1;
    end else if ((loc == t) && (glb != t)) begin
      if (m_cp[ph] != 2'd0) m_cp[ph] = m_cp[ph] - 2'd1;
    end
    if (t) begin
      if (m_lpt[lh] != 3'd7) m_lpt[lh] = m_lpt[lh] + 3'd1;
      if (m_gp[ph] != 2'd3)  m_gp[ph]  = m_gp[ph] + 2'd1;
    end else begin
      if (m_lpt[lh] != 3'd0) m_lpt[lh] = m_lpt[lh] - 3'd1;
      if (m_gp[ph] != 2'd0)  m_gp[ph]  = m_gp[ph] - 2'd1;
    end
    m_lht[pc] = {lh[8:0], t};
    m_ph      = {t, ph[11:1]};
    return pred;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Leaves the bench at a falling edge with reset released; the next rising
  // edge is phase 0 of a new slot.
  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    check("reset_pred", PredictedBranch, 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  // Runs one 8-cycle slot starting at a falling edge. With xmode set,
  // BranchTaken is X outside phase 4; PC is noise outside phase 0.
  task automatic run_slot(input logic [9:0] pc, input bit t, input bit xmode,
                          input bit use_const, input bit const_exp, input string tag);
    bit e;
    e = model_slot(pc, t);
    if (use_const) e = const_exp;
    exp_q.push_back(e);
    for (int p = 0; p < 8; p++) begin
      PC = (p == 0) ? pc : 10'($urandom);
      if (p == 4)     BranchTaken = t;
      else if (xmode) BranchTaken = 1'bx;
      else            BranchTaken = 1'($urandom);
      @(posedge clock);
      if (p == 3) begin
        #1;
        if (exp_q.size() == 0) check({tag, "_queue"}, 1, 0);
        else                   check(tag, PredictedBranch, exp_q.pop_front());
      end
      @(negedge clock);
    end
  endtask

  task automatic fill12();
    repeat (12) run_slot(10'd3, 1'b1, 1'b0, 1'b0, 1'b0, "t3_fill");
  endtask

  initial begin
    logic [9:0] b_pc [4];
    logic [1:0] b_cp [4];
    b_pc = '{10'd10, 10'd11, 10'd12, 10'd10};
    b_cp = '{2'd1, 2'd2, 2'd3, 2'd3};
    reset       = 1'b1;
    PC          = '0;
    BranchTaken = 1'b0;

    // Test 1: PC=0 always taken; predicts taken from slot 15 onward.
    do_reset(34);
    for (int s = 1; s <= 20; s++)
      run_slot(10'd0, 1'b1, 1'b0, 1'b1, (s >= 15), "t1_pred");

    // Test 4: reset in phase 2 of a trained slot clears everything.
    PC = 10'd0; BranchTaken = 1'b0;
    @(posedge clock); @(negedge clock);
    @(posedge clock); @(negedge clock);
    check("t4_pred_before", PredictedBranch, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("t4_pred_reset", PredictedBranch, 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    run_slot(10'd0, 1'b1, 1'b0, 1'b1, 1'b0, "t4_pred_pc0");
    run_slot(10'd7, 1'b1, 1'b0, 1'b1, 1'b0, "t4_pred_pc7");

    // Test 2: PC=5 never taken; nothing moves off zero.
    do_reset(3);
    for (int s = 0; s < 10; s++)
      run_slot(10'd5, 1'b0, 1'b0, 1'b1, 1'b0, "t2_pred");
    check("t2_path_hist", dut.path_hist, 0);
    check("t2_lpt0", dut.lpt[0], 0);
    check("t2_gp0", dut.gp[0], 0);
    check("t2_cp0", dut.cp[0], 0);

    // Test 3: choice counter at path history 0xFFF climbs, saturates at 3,
    // is driven back down and holds at 0.
    do_reset(3);
    for (int s = 0; s < 15; s++)
      run_slot(10'd3, 1'b1, 1'b0, 1'b0, 1'b0, "t3_pred");
    check("t3_cp_after_warm", dut.cp[12'hFFF], 0);
    check("t3_gp_after_warm", dut.gp[12'hFFF], 3);
    for (int i = 0; i < 4; i++) begin
      run_slot(b_pc[i], 1'b1, 1'b0, 1'b0, 1'b0, "t3_pred_up");
      check("t3_cp_up", dut.cp[12'hFFF], b_cp[i]);
    end
    run_slot(10'd50, 1'b0, 1'b0, 1'b0, 1'b0, "t3_pred_dn");
    check("t3_cp_nt1", dut.cp[12'hFFF], 3);
    fill12();
    run_slot(10'd50, 1'b0, 1'b0, 1'b0, 1'b0, "t3_pred_dn");
    check("t3_cp_nt2", dut.cp[12'hFFF], 2);
    fill12();
    run_slot(10'd3, 1'b1, 1'b0, 1'b0, 1'b0, "t3_pred_dn");
    check("t3_cp_t1", dut.cp[12'hFFF], 1);
    run_slot(10'd50, 1'b0, 1'b0, 1'b0, 1'b0, "t3_pred_dn");
    check("t3_cp_nt3", dut.cp[12'hFFF], 0);
    fill12();
    run_slot(10'd3, 1'b1, 1'b0, 1'b0, 1'b0, "t3_pred_dn");
    check("t3_cp_hold_t", dut.cp[12'hFFF], 0);
    run_slot(10'd50, 1'b0, 1'b0, 1'b0, 1'b0, "t3_pred_dn");
    check("t3_cp_hold_nt", dut.cp[12'hFFF], 0);

    // Test 5: interleaved PC=1 taken / PC=2 not taken against the model.
    do_reset(3);
    for (int s = 0; s < 40; s++) begin
      if (s % 2 == 0) run_slot(10'd1, 1'b1, 1'b0, 1'b0, 1'b0, "t5_pred");
      else            run_slot(10'd2, 1'b0, 1'b0, 1'b0, 1'b0, "t5_pred");
    end

    // Test 6: test 1 again with BranchTaken undriven outside phase 4.
    do_reset(34);
    for (int s = 1; s <= 20; s++)
      run_slot(10'd0, 1'b1, 1'b1, 1'b1, (s >= 15), "t6_pred");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
